// File: rtl/adc_sample_filter.sv
// adc_sample_filter: conditions the raw external ADC nibble for the fan
// controller core. The asynchronous strobe is synchronised and edge-detected,
// one sample is accepted per strobe rising edge, 2^AVG_LOG2 accepted samples
// are averaged with round-half-up, and the mean is delivered with a clean
// single-enabled-cycle strobe.
//
// Optional feature (macro ADC_SAMPLE_TIMEOUT_EN): sample-timeout watchdog.
// After TIMEOUT_CYCLES enabled cycles without an accept it raises fault_o,
// drives an all-ones value (fan to full speed) with one strobe, and clears
// the partial average. The next accept clears the fault.
//
// Ports:
//   clk_i             system clock
//   rstn_i            asynchronous active-low reset
//   clk_en_i          clock enable; every register advances only when 1
//   ADC_value_i       raw ADC sample (asynchronous)
//   dataVaild_STRB_i  raw sample strobe (asynchronous, level-high)
//   ADC_value_o       filtered (rounded mean) value, held between strobes
//   dataVaild_STRB_o  one-enabled-cycle pulse marking a new ADC_value_o
//   fault_o           sample-timeout fault (constant 0 without the macro)
module adc_sample_filter #(
  parameter int unsigned ADC_BITWIDTH   = 4,
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clk_en_i,
  input  logic [ADC_BITWIDTH-1:0] ADC_value_i,
  input  logic                    dataVaild_STRB_i,
  output logic [ADC_BITWIDTH-1:0] ADC_value_o,
  output logic                    dataVaild_STRB_o,
  output logic                    fault_o
);

  localparam int unsigned ACC_W = ADC_BITWIDTH + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 ** AVG_LOG2);
  // Half an LSB of the mean; zero for pass-through.
  localparam logic [ACC_W-1:0] RND = ACC_W'((2 ** AVG_LOG2) >> 1);

  // Elaboration guard on configuration.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout_cfg
    $error("adc_sample_filter: TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    s1_q, s2_q, s3_q;
  logic [ADC_BITWIDTH-1:0] d1_q, d2_q;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADC_BITWIDTH-1:0] val_q, val_d;
  logic                    strb_q, strb_d;
  logic                    accept;
  logic [ACC_W-1:0]        sample;
  logic [ACC_W-1:0]        rnd_sum;
  logic [ADC_BITWIDTH-1:0] mean;

`ifdef ADC_SAMPLE_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              fault_q, fault_d;
`endif

  // Rising edge of the synchronised strobe; d2_q is aligned with s2_q.
  assign accept  = s2_q & ~s3_q;
  assign sample  = ACC_W'(d2_q);
  assign rnd_sum = acc_q + RND;
  assign mean    = ADC_BITWIDTH'(rnd_sum >> AVG_LOG2);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    strb_d  = 1'b0;
`ifdef ADC_SAMPLE_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    fault_d = fault_q;
`endif
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          acc_d = acc_q + sample;
          cnt_d = cnt_q + CNT_W'(1);
          if ((cnt_q + CNT_W'(1)) == CNT_FULL) state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        val_d  = mean;
        strb_d = 1'b1;
        if (accept) begin
          // Accept during emit opens the next window.
          acc_d   = sample;
          cnt_d   = CNT_W'(1);
          state_d = (CNT_FULL == CNT_W'(1)) ? ST_EMIT : ST_ACCUM;
        end else begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
`ifdef ADC_SAMPLE_TIMEOUT_EN
    // Watchdog: an accept always wins over a coincident timeout.
    if (accept) begin
      tcnt_d  = '0;
      fault_d = 1'b0;
    end else if (tcnt_q == TCNT_LAST) begin
      tcnt_d  = TCNT_MAX;
      fault_d = 1'b1;
      val_d   = '1;
      strb_d  = 1'b1;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = ST_ACCUM;
    end else if (tcnt_q != TCNT_MAX) begin
      tcnt_d = tcnt_q + TCNT_W'(1);
    end
`endif
  end

  // State, synchroniser and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_ACCUM;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      strb_q  <= 1'b0;
`ifdef ADC_SAMPLE_TIMEOUT_EN
      tcnt_q  <= '0;
      fault_q <= 1'b0;
`endif
    end else if (clk_en_i) begin
      state_q <= state_d;
      s1_q    <= dataVaild_STRB_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      d1_q    <= ADC_value_i;
      d2_q    <= d1_q;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      strb_q  <= strb_d;
`ifdef ADC_SAMPLE_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      fault_q <= fault_d;
`endif
    end
  end

  assign ADC_value_o      = val_q;
  assign dataVaild_STRB_o = strb_q;
`ifdef ADC_SAMPLE_TIMEOUT_EN
  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

endmodule
